// File: rtl/uart_tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ctrl_pkg
//  Purpose  : Shared constants for the memory-mapped UART transmitter:
//             memory-map addresses, FSM state encoding, default baud divisor.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_ctrl_pkg;

   // Addresses decoded upstream by the load/store memory map.
   localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
   localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;

   // 100 MHz sysclk / 115200 baud.
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   localparam int DATA_BITS = 8;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t START = 2'd1;
   localparam state_t DATA  = 2'd2;
   localparam state_t STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ctrl_if
//  Purpose  : Store-path write channel and status flags between the core's
//             memory-map decode and the UART transmitter.
//  Signals  : wr_en    - one-cycle byte write strobe
//             wr_data  - byte to transmit
//             full     - transmit FIFO full
//             busy     - FIFO non-empty or a frame in flight
//             overflow - sticky dropped-write flag
//  Modports : master (core side), slave (UART side)
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_ctrl_if;

   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       busy;
   logic       overflow;

   modport master (
      output wr_en,
      output wr_data,
      input  full,
      input  busy,
      input  overflow
   );

   modport slave (
      input  wr_en,
      input  wr_data,
      output full,
      output busy,
      output overflow
   );

endinterface
`default_nettype wire

// File: rtl/uart_tx_ctrl_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Synchronous byte FIFO buffering store-path writes for the UART.
//             Head entry is presented combinationally on rd_data.
//  Ports    : sysclk, cpu_resetn (async, active-low)
//             wr_en/wr_data - push (accepted when not full, or when a pop
//                             happens in the same cycle)
//             rd_en         - pop the head (ignored when empty)
//             rd_data       - head entry
//             empty, full   - occupancy flags (full is a flop)
//             count         - number of stored entries
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int PTR_W      = 3
) (
   input  logic             sysclk,
   input  logic             cpu_resetn,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   input  logic             rd_en,
   output logic [7:0]       rd_data,
   output logic             empty,
   output logic             full,
   output logic [PTR_W:0]   count
);

   if ((1 << PTR_W) != FIFO_DEPTH || FIFO_DEPTH < 2) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be 2**PTR_W and at least 2");
   end

   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;
   logic [PTR_W:0]   count_nxt;

   assign empty   = (count == '0);
   assign do_rd   = rd_en && !empty;
   // A pop in the same cycle frees the slot, so a write while full still lands.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({do_wr, do_rd})
         2'b10:   count_nxt = count + (PTR_W + 1)'(1);
         2'b01:   count_nxt = count - (PTR_W + 1)'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_nxt;
         full  <= (count_nxt == DEPTH_CNT);
      end
   end

   // Storage needs no reset: entries are only read once count says valid.
   always_ff @(posedge sysclk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ctrl
//  Purpose  : Memory-mapped 8N1 UART transmitter. Buffers store-path bytes in
//             a FIFO and serialises them LSB first at CLKS_PER_BIT cycles/bit.
//  Ports    : sysclk     - system clock (rising edge)
//             cpu_resetn - asynchronous active-low reset
//             bus        - slave side of uart_tx_ctrl_if
//                          (wr_en, wr_data, full, busy, overflow)
//             uart_tx    - serial line, idle high, registered
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 8,
   parameter int PTR_W        = 3
) (
   input  logic           sysclk,
   input  logic           cpu_resetn,
   uart_tx_ctrl_if.slave  bus,
   output logic           uart_tx
);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_ctrl: CLKS_PER_BIT must be at least 2");
   end

   localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_nxt;
   logic [7:0]       sh;
   logic [7:0]       sh_nxt;
   logic             tx_nxt;
   logic             pop;
   logic             overflow;

   logic             fifo_empty;
   logic             fifo_full;
   logic [7:0]       fifo_rd_data;
   logic [PTR_W:0]   fifo_count;

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .PTR_W      (PTR_W)
   ) u_fifo (
      .sysclk     (sysclk),
      .cpu_resetn (cpu_resetn),
      .wr_en      (bus.wr_en),
      .wr_data    (bus.wr_data),
      .rd_en      (pop),
      .rd_data    (fifo_rd_data),
      .empty      (fifo_empty),
      .full       (fifo_full),
      .count      (fifo_count)
   );

   // ------------------------------------------------------------------------
   // State register (FSM plus the datapath it sequences)
   // ------------------------------------------------------------------------
   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         sh      <= '0;
         uart_tx <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         sh      <= sh_nxt;
         uart_tx <= tx_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      sh_nxt    = sh;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               sh_nxt    = fifo_rd_data;
               cnt_nxt   = '0;
               state_nxt = START;
            end
         end
         START: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               bit_nxt   = '0;
               state_nxt = DATA;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               sh_nxt  = {1'b0, sh[7:1]};
               if (bit_idx == 3'(DATA_BITS - 1)) begin
                  state_nxt = STOP;
               end else begin
                  bit_nxt = bit_idx + 3'd1;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               // Chain straight into the next frame so back-to-back bytes
               // leave no idle gap on the line.
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  sh_nxt    = fifo_rd_data;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic: the line value is computed from the next state so the
   // flop shows it in the same cycle the state is entered.
   // ------------------------------------------------------------------------
   always_comb begin
      tx_nxt = 1'b1;
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = sh_nxt[0];
         default: tx_nxt = 1'b1;
      endcase
   end

   // Sticky until reset: a write arrived while full and no pop freed a slot.
   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         overflow <= 1'b0;
      end else if (bus.wr_en && fifo_full && !pop) begin
         overflow <= 1'b1;
      end
   end

   assign bus.full     = fifo_full;
   assign bus.busy     = (fifo_count != '0) || (state != IDLE);
   assign bus.overflow = overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_ctrl
//  Purpose  : Self-checking bench for uart_tx_ctrl. A frame-level reference
//             model (byte queue + position within the current 10-bit frame)
//             predicts the line and flags every cycle; a line decoder checks
//             byte order; vector table and directed sequences cover corners.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

   localparam int CPB   = 4;
   localparam int DEPTH = 8;
   localparam int PW    = 3;
   localparam int FRAME = 10 * CPB;

   logic sysclk     = 1'b0;
   logic cpu_resetn = 1'b1;
   logic uart_tx;

   uart_tx_ctrl_if bus ();

   uart_tx_ctrl #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .PTR_W        (PW)
   ) dut (
      .sysclk     (sysclk),
      .cpu_resetn (cpu_resetn),
      .bus        (bus),
      .uart_tx    (uart_tx)
   );

   initial forever #5 sysclk = ~sysclk;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;
   logic [7:0]  rxq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: queued bytes plus the position inside the frame being
   // sent (-1 when the line is idle).
   // ------------------------------------------------------------------------
   logic [7:0] mq[$];
   int         pos;
   logic [7:0] cur;
   logic       movf;

   function automatic void model_reset();
      mq.delete();
      pos  = -1;
      cur  = '0;
      movf = 1'b0;
   endfunction

   function automatic void model_step(input logic we, input logic [7:0] wd);
      int sz;
      bit pp;
      sz = mq.size();
      // A byte is taken from the queue when the line is free or the current
      // frame is in its final cycle; a byte arriving this edge is not visible.
      pp = (sz > 0) && (pos < 0 || pos == FRAME - 1);
      if (pos == FRAME - 1)  pos = -1;
      else if (pos >= 0)     pos++;
      if (pp) begin
         cur = mq.pop_front();
         pos = 0;
      end
      if (we) begin
         if (sz < DEPTH || pp) mq.push_back(wd);
         else                  movf = 1'b1;
      end
   endfunction

   function automatic logic model_line();
      int slot;
      if (pos < 0) return 1'b1;
      slot = pos / CPB;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return cur[slot-1];
   endfunction

   initial begin
      forever begin
         @(posedge sysclk);
         cyc++;
         if (!cpu_resetn) model_reset();
         else             model_step(bus.wr_en, bus.wr_data);
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      #2;
      forever begin
         @(negedge sysclk);
         chk("line",     {31'd0, uart_tx},      {31'd0, model_line()});
         chk("busy",     {31'd0, bus.busy},     {31'd0, (pos >= 0 || mq.size() > 0)});
         chk("full",     {31'd0, bus.full},     {31'd0, (mq.size() == DEPTH)});
         chk("overflow", {31'd0, bus.overflow}, {31'd0, movf});
      end
   end

   // Line decoder: sample each bit at its centre.
   initial begin
      logic [7:0] b;
      b = '0;
      forever begin
         @(negedge sysclk);
         if (cpu_resetn === 1'b1 && uart_tx === 1'b0) begin
            repeat (CPB / 2) @(negedge sysclk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge sysclk);
               b[i] = uart_tx;
            end
            repeat (CPB) @(negedge sysclk);
            chk("rx_stop_bit", {31'd0, uart_tx}, 32'd1);
            rxq.push_back(b);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic write_byte(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      @(negedge sysclk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int k;
      k = 0;
      while (bus.busy !== 1'b0 && k < maxc) begin
         @(negedge sysclk);
         k++;
      end
      chk("idle_wait", {31'd0, bus.busy}, 32'd0);
      repeat (2) @(negedge sysclk);
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      cpu_resetn = 1'b0;
      model_reset();
      repeat (2) @(negedge sysclk);
      cpu_resetn = 1'b1;
      @(negedge sysclk);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit k = expected line level in bit slot k
   } vec_t;

   vec_t       vecs [5];
   logic [7:0] exp_q[$];

   initial begin
      int         span;
      int         n0;
      int         k;
      logic [7:0] d;

      vecs[0] = '{8'h55, 10'b1010101010};
      vecs[1] = '{8'hA3, 10'b1101000110};
      vecs[2] = '{8'h00, 10'b1000000000};
      vecs[3] = '{8'hFF, 10'b1111111110};
      vecs[4] = '{8'h0F, 10'b1000011110};

      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      model_reset();

      // ---- reset, with write strobes ignored while held ----
      #1 cpu_resetn = 1'b0;
      @(negedge sysclk);
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hA5;
      repeat (3) @(negedge sysclk);
      chk("reset_tx",       {31'd0, uart_tx},      32'd1);
      chk("reset_busy",     {31'd0, bus.busy},     32'd0);
      chk("reset_full",     {31'd0, bus.full},     32'd0);
      chk("reset_overflow", {31'd0, bus.overflow}, 32'd0);
      bus.wr_en  = 1'b0;
      cpu_resetn = 1'b1;
      repeat (3) @(negedge sysclk);
      chk("post_reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("post_reset_tx",   {31'd0, uart_tx},  32'd1);

      // ---- single-byte frames from the vector table ----
      for (int v = 0; v < 5; v++) begin
         write_byte(vecs[v].data);
         repeat (CPB / 2 + 1) @(negedge sysclk);
         for (int s = 0; s < 10; s++) begin
            if (s > 0) repeat (CPB) @(negedge sysclk);
            chk($sformatf("vec%0d_slot%0d", v, s), {31'd0, uart_tx}, {31'd0, vecs[v].frame[s]});
         end
         @(negedge sysclk);
         chk($sformatf("vec%0d_busy_hold", v), {31'd0, bus.busy}, 32'd1);
         @(negedge sysclk);
         chk($sformatf("vec%0d_busy_fall", v), {31'd0, bus.busy}, 32'd0);
         if (rxq.size() > 0) chk($sformatf("vec%0d_rx", v), {24'd0, rxq.pop_front()}, {24'd0, vecs[v].data});
         else                chk($sformatf("vec%0d_rx_count", v), 32'd0, 32'd1);
      end
      repeat (4) @(negedge sysclk);
      rxq.delete();

      // ---- back-to-back frames ----
      write_byte(8'hA3);
      write_byte(8'h0F);
      span = 0;
      while (bus.busy && span < 200) begin
         @(negedge sysclk);
         span++;
      end
      chk("b2b_span", span, 32'd80);
      repeat (2) @(negedge sysclk);
      chk("b2b_rx_count", rxq.size(), 32'd2);
      if (rxq.size() == 2) begin
         chk("b2b_rx0", {24'd0, rxq[0]}, 32'hA3);
         chk("b2b_rx1", {24'd0, rxq[1]}, 32'h0F);
      end
      rxq.delete();

      // ---- reset mid-frame: line forced high at once, queue discarded ----
      write_byte(8'h00);
      write_byte(8'h11);
      repeat (10) @(negedge sysclk);
      #2;
      cpu_resetn = 1'b0;
      model_reset();
      #1;
      chk("async_reset_tx",   {31'd0, uart_tx},  32'd1);
      chk("async_reset_busy", {31'd0, bus.busy}, 32'd0);
      repeat (2) @(negedge sysclk);
      cpu_resetn = 1'b1;
      repeat (5) @(negedge sysclk);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_tx",   {31'd0, uart_tx},  32'd1);
      repeat (50) @(negedge sysclk);
      rxq.delete();

      // ---- random stream, writes gated on full (pointer wrap) ----
      exp_q.delete();
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge sysclk);
         k = 0;
         while (bus.full && k < 500) begin
            @(negedge sysclk);
            k++;
         end
         if (k >= 500) chk("wrap_full_wait", {31'd0, bus.full}, 32'd0);
         d = 8'($urandom);
         write_byte(d);
         exp_q.push_back(d);
      end
      wait_idle(2000);
      chk("wrap_rx_count", rxq.size(), 32'd20);
      for (int i = 0; i < 20 && i < rxq.size(); i++)
         chk($sformatf("wrap_rx%0d", i), {24'd0, rxq[i]}, {24'd0, exp_q[i]});
      chk("wrap_overflow", {31'd0, bus.overflow}, 32'd0);
      rxq.delete();

      // ---- fill and overflow ----
      for (int i = 0; i < 10; i++) begin
         write_byte(8'(i));
         if (i == 7) chk("fill_not_full", {31'd0, bus.full}, 32'd0);
         if (i == 8) chk("fill_full",     {31'd0, bus.full}, 32'd1);
      end
      chk("fill_overflow", {31'd0, bus.overflow}, 32'd1);
      wait_idle(1000);
      chk("fill_rx_count", rxq.size(), 32'd9);
      for (int i = 0; i < 9 && i < rxq.size(); i++)
         chk($sformatf("fill_rx%0d", i), {24'd0, rxq[i]}, i);
      chk("fill_overflow_sticky", {31'd0, bus.overflow}, 32'd1);
      do_reset();
      chk("overflow_cleared", {31'd0, bus.overflow}, 32'd0);
      rxq.delete();

      // ---- write while full on the STOP-end pop cycle ----
      write_byte(8'hC0);
      n0 = int'(cyc);
      for (int j = 1; j <= 8; j++) write_byte(8'hC0 + 8'(j));
      chk("fp_full", {31'd0, bus.full}, 32'd1);
      while (int'(cyc) < n0 + 40) @(negedge sysclk);
      write_byte(8'hEE);
      chk("fp_full_after",     {31'd0, bus.full},     32'd1);
      chk("fp_overflow_after", {31'd0, bus.overflow}, 32'd0);
      wait_idle(1000);
      chk("fp_rx_count", rxq.size(), 32'd10);
      for (int i = 0; i < 9 && i < rxq.size(); i++)
         chk($sformatf("fp_rx%0d", i), {24'd0, rxq[i]}, 32'hC0 + i);
      if (rxq.size() == 10) chk("fp_rx9", {24'd0, rxq[9]}, 32'hEE);
      chk("fp_overflow_end", {31'd0, bus.overflow}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
